// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
package seg7_pkg;

  localparam int unsigned N_DIGITS = 4;
  localparam int unsigned IDX_W    = $clog2(N_DIGITS);
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned VAL_W    = N_DIGITS * NIB_W;
  localparam int unsigned SEG_W    = 7;

  typedef enum logic {
    BLANK,
    DRIVE
  } state_t;

  typedef struct packed {
    logic [VAL_W-1:0]    value;
    logic [N_DIGITS-1:0] dp;
    logic [N_DIGITS-1:0] en;
  } upd_t;

  // Active-high abcdefg patterns, entry n is the glyph for hex digit n
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  // Digit n stays lit only if some nibble at or above n is non-zero; digit 0 always lit
  function automatic logic [N_DIGITS-1:0] lz_mask(input logic [VAL_W-1:0] v);
    return {|v[15:12], |v[15:8], |v[15:4], 1'b1};
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Update handshake between client logic and the 7-segment scanner.
interface seg7_scan_ctrl_if;
  import seg7_pkg::*;

  logic                upd_valid;
  logic                upd_ready;
  logic [VAL_W-1:0]    upd_value;
  logic [N_DIGITS-1:0] upd_dp;
  logic [N_DIGITS-1:0] upd_digit_en;

  modport master (
    output upd_valid, upd_value, upd_dp, upd_digit_en,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_value, upd_dp, upd_digit_en,
    output upd_ready
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Nibble to active-high abcdefg segment pattern; polarity is applied by the caller.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);
  assign seg_c = SEG_TABLE[nibble];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Round-robin 4-digit 7-segment scanner with guard blanking and frame-aligned updates.
// Optional leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 25000000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned BLANK_CYCLES   = 64,
  parameter int unsigned AN_ACTIVE_LOW  = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                app_clk,
  input  logic                app_arst,
  seg7_scan_ctrl_if.slave     upd,
  output logic [N_DIGITS-1:0] AN,
  output logic [SEG_W-1:0]    A_TO_G,
  output logic                DOT,
  output logic                frame_done
);

  localparam int unsigned DIGIT_CYCLES = CLK_HZ / (N_DIGITS * SCAN_HZ);
  localparam int unsigned DRIVE_CYCLES = DIGIT_CYCLES - BLANK_CYCLES;
  localparam int unsigned CNT_W        = $clog2(DIGIT_CYCLES + 1);

  localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0]    SEG_OFF = {SEG_W{SEG_INV}};

  if (DIGIT_CYCLES <= BLANK_CYCLES) begin : g_bad_timing
    $error("seg7_scan_ctrl: digit slot must be longer than BLANK_CYCLES");
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                frame_end_c, commit_c, accept_c;
  upd_t                shadow_q, shadow_d, active_q, active_d;
  logic                full_q, full_d, ready_q;
  logic [NIB_W-1:0]    nib_c;
  logic [SEG_W-1:0]    seg_c, seg_d;
  logic [N_DIGITS-1:0] an_d;
  logic                dot_d, fd_d;

  // Slot scheduler: BLANK guard then DRIVE, advancing the digit index per slot
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    frame_end_c = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_W'(DRIVE_CYCLES - 1)) begin
          state_d     = BLANK;
          cnt_d       = '0;
          idx_d       = idx_q + IDX_W'(1);
          frame_end_c = (idx_q == IDX_W'(N_DIGITS - 1));
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
    fd_d = (state_d == DRIVE) && (idx_d == IDX_W'(N_DIGITS - 1)) &&
           (cnt_d == CNT_W'(DRIVE_CYCLES - 1));
  end

  // Shadow capture and frame-boundary commit; shadow is full on a commit so they never coincide
  always_comb begin
    accept_c = upd.upd_valid && ready_q;
    commit_c = frame_end_c && full_q;
    shadow_d = shadow_q;
    full_d   = full_q;
    active_d = active_q;
    if (commit_c) begin
      full_d   = 1'b0;
      active_d = shadow_q;
`ifdef SEG7_LZ_BLANK_EN
      active_d.en = shadow_q.en & lz_mask(shadow_q.value);
`endif
    end
    if (accept_c) begin
      full_d         = 1'b1;
      shadow_d.value = upd.upd_value;
      shadow_d.dp    = upd.upd_dp;
      shadow_d.en    = upd.upd_digit_en;
    end
  end

  assign nib_c = active_d.value[{idx_d, 2'b00} +: NIB_W];

  seg7_hex_decode u_dec (
    .nibble (nib_c),
    .seg_c  (seg_c)
  );

  // Display outputs for the upcoming cycle; a disabled digit keeps everything dark
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dot_d = SEG_INV;
    if ((state_d == DRIVE) && active_d.en[idx_d]) begin
      an_d[idx_d] = ~AN_OFF[idx_d];
      seg_d       = seg_c ^ SEG_OFF;
      dot_d       = active_d.dp[idx_d] ^ SEG_INV;
    end
  end

  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      full_q     <= 1'b0;
      ready_q    <= 1'b1;
      AN         <= AN_OFF;
      A_TO_G     <= SEG_OFF;
      DOT        <= SEG_INV;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      full_q     <= full_d;
      ready_q    <= ~full_d;
      AN         <= an_d;
      A_TO_G     <= seg_d;
      DOT        <= dot_d;
      frame_done <= fd_d;
    end
  end

  assign upd.upd_ready = ready_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl using a 10-cycle digit slot (2 blank + 8 drive).
module tb_seg7_scan_ctrl;

  localparam int unsigned CLK_HZ  = 4000;
  localparam int unsigned SCAN_HZ = 100;
  localparam int unsigned BLANK   = 2;
  localparam int unsigned SLOT    = 10;

  // Active-high abcdefg glyphs for 0..F, written out by hand
  localparam logic [6:0] REF_SEG [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  logic       app_clk = 1'b0;
  logic       app_arst;
  logic [3:0] AN;
  logic [6:0] A_TO_G;
  logic       DOT;
  logic       frame_done;
  int         checks = 0;
  int         errors = 0;
  int         n;

  seg7_scan_ctrl_if u_if ();

  seg7_scan_ctrl #(
    .CLK_HZ         (CLK_HZ),
    .SCAN_HZ        (SCAN_HZ),
    .BLANK_CYCLES   (BLANK),
    .AN_ACTIVE_LOW  (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .app_clk    (app_clk),
    .app_arst   (app_arst),
    .upd        (u_if),
    .AN         (AN),
    .A_TO_G     (A_TO_G),
    .DOT        (DOT),
    .frame_done (frame_done)
  );

  always #5 app_clk = ~app_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge app_clk);
    #1;
  endtask

  // Expected {AN, A_TO_G, DOT} for digit k at position j within its slot
  function automatic logic [11:0] exp_disp(input logic [15:0] v, input logic [3:0] dp,
                                           input logic [3:0] en, input int k, input int j);
    logic [3:0] nib;
    logic [3:0] an;
    logic       on;
    logic       all_zero;
    nib = v[k*4 +: 4];
    on  = en[k];
    all_zero = 1'b1;
    for (int m = k; m < 4; m++) if (v[m*4 +: 4] != 4'h0) all_zero = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    if (k > 0 && all_zero) on = 1'b0;
`endif
    if (j < int'(BLANK) || !on) return {4'hF, 7'h7F, 1'b1};
    an    = 4'hF;
    an[k] = 1'b0;
    return {an, ~REF_SEG[nib], ~dp[k]};
  endfunction

  // Starting on a frame_done cycle, check one whole frame and end on the next frame_done
  task automatic check_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < int'(SLOT); j++) begin
        step();
        chk("disp", {20'h0, AN, A_TO_G, DOT}, {20'h0, exp_disp(v, dp, en, k, j)});
        chk("frame_done", {31'h0, frame_done}, {31'h0, (k == 3 && j == int'(SLOT) - 1)});
        if (k == 0 && j == 0) chk("ready_after_frame", {31'h0, u_if.upd_ready}, 32'h1);
        if (k == 0 && j == 1) u_if.upd_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_fd(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (frame_done !== 1'b1 && cnt < 100);
    chk("frame_done_seen", {31'h0, frame_done}, 32'h1);
  endtask

  task automatic accept(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                        input logic hold);
    u_if.upd_valid    = 1'b1;
    u_if.upd_value    = v;
    u_if.upd_dp       = dp;
    u_if.upd_digit_en = en;
    step();
    chk("ready_drop", {31'h0, u_if.upd_ready}, 32'h0);
    if (!hold) u_if.upd_valid = 1'b0;
  endtask

  task automatic chk_dark(input string tag);
    chk(tag, {20'h0, AN, A_TO_G, DOT}, {20'h0, 4'hF, 7'h7F, 1'b1});
    chk("fd_low", {31'h0, frame_done}, 32'h0);
    chk("ready_reset", {31'h0, u_if.upd_ready}, 32'h1);
  endtask

  initial begin
    app_arst          = 1'b1;
    u_if.upd_valid    = 1'b0;
    u_if.upd_value    = 16'h0;
    u_if.upd_dp       = 4'h0;
    u_if.upd_digit_en = 4'h0;
    repeat (3) step();
    chk_dark("reset_outputs");

    // Idle scan: first frame boundary 39 cycles after release, then a dark frame
    app_arst = 1'b0;
    wait_fd(n);
    chk("first_frame_len", 32'(n), 32'd39);
    check_frame(16'h0, 4'h0, 4'h0);

    // Single update shows from the following frame
    accept(16'h12AF, 4'b0100, 4'hF, 1'b0);
    wait_fd(n);
    chk("frame_len_upd", 32'(n), 32'd39);
    check_frame(16'h12AF, 4'b0100, 4'hF);

    // Back-to-back updates: second waits in upd_valid until the shadow drains
    accept(16'h3456, 4'b0001, 4'hF, 1'b1);
    u_if.upd_value = 16'h789C;
    u_if.upd_dp    = 4'b1000;
    wait_fd(n);
    chk("ready_held_low", {31'h0, u_if.upd_ready}, 32'h0);
    check_frame(16'h3456, 4'b0001, 4'hF);
    check_frame(16'h789C, 4'b1000, 4'hF);

    // Asynchronous reset in the middle of digit 2's drive phase
    repeat (25) step();
    chk("pre_reset_d2", {20'h0, AN, A_TO_G, DOT},
        {20'h0, exp_disp(16'h789C, 4'b1000, 4'hF, 2, 4)});
    app_arst = 1'b1;
    #1;
    chk_dark("async_reset");
    repeat (2) step();
    app_arst = 1'b0;
    wait_fd(n);
    chk("restart_frame_len", 32'(n), 32'd39);
    check_frame(16'h0, 4'h0, 4'h0);

    // Partial enable: disabled slots stay dark but keep their timing
    accept(16'h4321, 4'h0, 4'b1010, 1'b0);
    wait_fd(n);
    check_frame(16'h4321, 4'h0, 4'b1010);

    // Leading zeros (blanked only when the optional feature is built in)
    accept(16'h0005, 4'h0, 4'hF, 1'b0);
    wait_fd(n);
    check_frame(16'h0005, 4'h0, 4'hF);
    accept(16'h0000, 4'h0, 4'hF, 1'b0);
    wait_fd(n);
    check_frame(16'h0000, 4'h0, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
